// File: rtl/stream_xbar_pkg.sv
// -----------------------------------------------------------------------------
// stream_xbar_pkg
// Shared constants, types and helpers for the stream crossbar switch.
//   SEL_IDLE   : ctrl_sel_in value meaning "no input selected"
//   SEL_MIN    : lowest select value that addresses a real input port
//   route_state_e : route/lock FSM states
//   clog2()    : ceiling log2 usable in parameter expressions
//   sel_legal(): route legality check (select in range and non-empty mask)
// -----------------------------------------------------------------------------
package stream_xbar_pkg;

    localparam int SEL_IDLE = 0;
    localparam int SEL_MIN  = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } route_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic sel_legal(input int sel, input int n_in, input logic mask_nz);
        return (sel >= SEL_MIN) && (sel <= n_in) && mask_nz;
    endfunction

endpackage

// File: rtl/stream_xbar_switch_skid.sv
// -----------------------------------------------------------------------------
// xbar_skid_buf
// Two-entry FIFO holding accepted beats until every destination has taken them.
//   clk, rst_n : clock, synchronous active-low reset (empties the buffer)
//   i_push     : write i_data (ignored when full)
//   i_data     : payload, W bits
//   o_full     : both entries occupied; registered, so upstream ready has no
//                combinational dependency on downstream handshakes
//   o_valid    : head entry present
//   o_data     : head entry payload
//   i_pop      : discard head entry (ignored when empty)
// -----------------------------------------------------------------------------
module xbar_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_pop
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & o_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: contents are only observed through o_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/stream_xbar_switch.sv
// -----------------------------------------------------------------------------
// stream_xbar_switch
// Routes one of N_IN AXI-stream inputs to a multicast set of N_OUT outputs.
// The route is sampled from ctrl_* while idle and locked for the rest of a
// multi-beat packet. Beats pass through a 2-entry buffer carrying their own
// destination mask; the output side forks eagerly, each output taking the
// head beat independently, and the head pops once all destinations have it.
//   clk, rst_n            : clock, synchronous active-low reset
//   ctrl_sel_in           : 0 = idle, k = input port k-1
//   ctrl_out_mask         : destination mask (multicast)
//   s_tdata/s_tlast       : packed per-input payload
//   s_tvalid/s_tready     : per-input handshake
//   m_tdata/m_tlast       : shared output payload (head of buffer)
//   m_tvalid/m_tready     : per-output handshake
//   cnt_clr, beat_count   : accepted-beat counter and its clear
//   pkt_active            : a multi-beat route is locked
//   err_sel               : sticky illegal-route flag
// -----------------------------------------------------------------------------
module stream_xbar_switch
    import stream_xbar_pkg::*;
#(
    parameter  int DATA_W = 1536,
    parameter  int LAST_W = 12,
    parameter  int N_IN   = 6,
    parameter  int N_OUT  = 9,
    localparam int SEL_W  = clog2(N_IN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_W-1:0]       ctrl_sel_in,
    input  logic [N_OUT-1:0]       ctrl_out_mask,
    input  logic [N_IN*DATA_W-1:0] s_tdata,
    input  logic [N_IN*LAST_W-1:0] s_tlast,
    input  logic [N_IN-1:0]        s_tvalid,
    output logic [N_IN-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic [LAST_W-1:0]      m_tlast,
    output logic [N_OUT-1:0]       m_tvalid,
    input  logic [N_OUT-1:0]       m_tready,
    input  logic                   cnt_clr,
    output logic [31:0]            beat_count,
    output logic                   pkt_active,
    output logic                   err_sel
);

    localparam int PAY_W = N_OUT + LAST_W + DATA_W;

    route_state_e      r_state;
    route_state_e      w_state_nxt;
    logic [SEL_W-1:0]  r_lock_sel;
    logic [N_OUT-1:0]  r_lock_mask;
    logic              w_lock_en;
    logic [SEL_W-1:0]  w_sel;
    logic [N_OUT-1:0]  w_mask;
    logic              w_legal;
    logic              w_idle_err;
    logic [DATA_W-1:0] w_in_data;
    logic [LAST_W-1:0] w_in_last;
    logic              w_acc;
    logic              w_buf_full;
    logic              w_head_vld;
    logic [PAY_W-1:0]  w_head;
    logic [N_OUT-1:0]  w_head_mask;
    logic [N_OUT-1:0]  w_hs;
    logic              w_pop;
    logic [N_OUT-1:0]  r_done;
    logic [31:0]       r_beat_cnt;
    logic              r_err;

    // ---------------- route selection ----------------
    assign w_sel   = (r_state == ST_LOCKED) ? r_lock_sel  : ctrl_sel_in;
    assign w_mask  = (r_state == ST_LOCKED) ? r_lock_mask : ctrl_out_mask;
    assign w_legal = sel_legal(int'(w_sel), N_IN, |w_mask);
    // Select 0 is a deliberate "no route" request, not an error.
    assign w_idle_err = (r_state == ST_IDLE) && (w_sel != SEL_W'(SEL_IDLE)) && !w_legal;

    // Input mux. Ready depends only on route and registered buffer fullness.
    always_comb begin
        s_tready  = '0;
        w_in_data = '0;
        w_in_last = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_sel == SEL_W'(i + 1)) begin
                s_tready[i] = rst_n & w_legal & ~w_buf_full;
                w_in_data   = s_tdata[i*DATA_W +: DATA_W];
                w_in_last   = s_tlast[i*LAST_W +: LAST_W];
            end
        end
    end

    assign w_acc = |(s_tvalid & s_tready);

    // ---------------- route/lock FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_lock_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_lock_en = w_acc;
                // A beat carrying tlast is a whole packet: stay idle.
                if (w_acc && !w_in_last[0]) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_acc && w_in_last[0]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_sel  <= '0;
            r_lock_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_lock_en) begin
                r_lock_sel  <= ctrl_sel_in;
                r_lock_mask <= ctrl_out_mask;
            end
        end
    end

    // ---------------- buffer ----------------
    xbar_skid_buf #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc),
        .i_data  ({w_mask, w_in_last, w_in_data}),
        .o_full  (w_buf_full),
        .o_valid (w_head_vld),
        .o_data  (w_head),
        .i_pop   (w_pop)
    );

    // ---------------- eager fork ----------------
    assign w_head_mask = w_head[PAY_W-1 -: N_OUT];
    assign m_tlast     = w_head[DATA_W +: LAST_W];
    assign m_tdata     = w_head[DATA_W-1:0];
    // Gated by rst_n so no output handshake can happen in a reset cycle.
    assign m_tvalid    = {N_OUT{rst_n & w_head_vld}} & w_head_mask & ~r_done;
    assign w_hs        = m_tvalid & m_tready;
    // Pop once every destination has either already taken the beat or takes it now.
    assign w_pop       = rst_n & w_head_vld & (&(r_done | w_hs | ~w_head_mask));

    always_ff @(posedge clk) begin
        if (!rst_n)     r_done <= '0;
        else if (w_pop) r_done <= '0;
        else            r_done <= r_done | w_hs;
    end

    // ---------------- counter / error ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (cnt_clr)    r_beat_cnt <= '0;
            else if (w_acc) r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_idle_err) r_err <= 1'b1;
        end
    end

    assign beat_count = r_beat_cnt;
    assign pkt_active = (r_state == ST_LOCKED);
    assign err_sel    = r_err;

endmodule

// File: tb/tb_stream_xbar_switch.sv
module tb_stream_xbar_switch;

    localparam int DW = 16;
    localparam int LW = 2;
    localparam int NI = 6;
    localparam int NO = 9;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SW-1:0]    ctrl_sel_in;
    logic [NO-1:0]    ctrl_out_mask;
    logic [NI*DW-1:0] s_tdata;
    logic [NI*LW-1:0] s_tlast;
    logic [NI-1:0]    s_tvalid;
    logic [NI-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [LW-1:0]    m_tlast;
    logic [NO-1:0]    m_tvalid;
    logic [NO-1:0]    m_tready;
    logic             cnt_clr;
    logic [31:0]      beat_count;
    logic             pkt_active;
    logic             err_sel;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_on  = 1'b0;

    always #5 clk = ~clk;

    stream_xbar_switch #(
        .DATA_W(DW), .LAST_W(LW), .N_IN(NI), .N_OUT(NO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_sel_in(ctrl_sel_in), .ctrl_out_mask(ctrl_out_mask),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .cnt_clr(cnt_clr), .beat_count(beat_count), .pkt_active(pkt_active), .err_sel(err_sel)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Beats waiting for delivery, each with the set of outputs still owed it.
    typedef struct {
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        logic [NO-1:0] rem;
    } beat_t;

    beat_t         q[$];
    bit            m_locked = 1'b0;
    int            m_lsel   = 0;
    logic [NO-1:0] m_lmask  = '0;
    bit            m_err    = 1'b0;
    logic [31:0]   m_cnt    = '0;

    always @(negedge clk) begin
        int            sel;
        logic [NO-1:0] msk;
        logic [NI-1:0] exp_rdy;
        logic [NO-1:0] exp_mv;
        logic [NO-1:0] hs;
        bit            legal;
        bit            acc;
        beat_t         b;
        if (mdl_on) begin
            sel   = m_locked ? m_lsel : int'(ctrl_sel_in);
            msk   = m_locked ? m_lmask : ctrl_out_mask;
            legal = (sel >= 1) && (sel <= NI) && (msk != '0);
            exp_rdy = '0;
            if (rst_n && legal && q.size() < 2) exp_rdy[sel-1] = 1'b1;
            exp_mv = (rst_n && q.size() > 0) ? q[0].rem : '0;

            chk("mdl_s_tready", 64'(s_tready), 64'(exp_rdy));
            chk("mdl_m_tvalid", 64'(m_tvalid), 64'(exp_mv));
            if (exp_mv != '0) begin
                chk("mdl_m_tdata", 64'(m_tdata), 64'(q[0].d));
                chk("mdl_m_tlast", 64'(m_tlast), 64'(q[0].l));
            end
            chk("mdl_pkt_active", 64'(pkt_active), 64'(m_locked));
            chk("mdl_err_sel", 64'(err_sel), 64'(m_err));
            chk("mdl_beat_count", 64'(beat_count), 64'(m_cnt));

            if (!rst_n) begin
                q.delete();
                m_locked = 1'b0;
                m_lsel   = 0;
                m_lmask  = '0;
                m_err    = 1'b0;
                m_cnt    = '0;
            end else begin
                hs = exp_mv & m_tready;
                if (q.size() > 0) begin
                    q[0].rem = q[0].rem & ~hs;
                    if (q[0].rem == '0) void'(q.pop_front());
                end
                if (!m_locked && sel != 0 && !legal) m_err = 1'b1;
                acc = |(exp_rdy & s_tvalid);
                if (acc) begin
                    b.d   = s_tdata[(sel-1)*DW +: DW];
                    b.l   = s_tlast[(sel-1)*LW +: LW];
                    b.rem = msk;
                    q.push_back(b);
                    if (!m_locked && !b.l[0]) begin
                        m_locked = 1'b1;
                        m_lsel   = sel;
                        m_lmask  = msk;
                    end else if (m_locked && b.l[0]) begin
                        m_locked = 1'b0;
                    end
                end
                if (cnt_clr)  m_cnt = '0;
                else if (acc) m_cnt = m_cnt + 32'd1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        cnt_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic put_beat(input int p, input logic [DW-1:0] d, input logic l0);
        s_tvalid[p]            = 1'b1;
        s_tdata[p*DW +: DW]    = d;
        s_tlast[p*LW +: LW]    = {{(LW-1){1'b0}}, l0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [SW-1:0] sel;
        logic [NO-1:0] mask;
        logic [NI-1:0] rdy;
        logic          err;
    } vec_t;

    initial begin
        vec_t          tbl [7];
        logic [NO-1:0] mv38 [6];

        tbl[0] = '{sel: 3'd1, mask: 9'h001, rdy: 6'b000001, err: 1'b0};
        tbl[1] = '{sel: 3'd6, mask: 9'h100, rdy: 6'b100000, err: 1'b0};
        tbl[2] = '{sel: 3'd0, mask: 9'h0ff, rdy: 6'b000000, err: 1'b0};
        tbl[3] = '{sel: 3'd7, mask: 9'h001, rdy: 6'b000000, err: 1'b1};
        tbl[4] = '{sel: 3'd3, mask: 9'h000, rdy: 6'b000000, err: 1'b1};
        tbl[5] = '{sel: 3'd2, mask: 9'h1ff, rdy: 6'b000010, err: 1'b0};
        tbl[6] = '{sel: 3'd4, mask: 9'h020, rdy: 6'b001000, err: 1'b0};

        rst_n = 1'b0;
        ctrl_sel_in = '0;
        ctrl_out_mask = '0;
        m_tready = '0;
        drive_idle();
        nxt();
        mdl_on = 1'b1;

        // reset state (rst_n still low)
        #2;
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_pkt_active", 64'(pkt_active), 64'(0));
        chk("rst_err_sel", 64'(err_sel), 64'(0));
        chk("rst_beat_count", 64'(beat_count), 64'(0));

        // route legality table
        for (int k = 0; k < 7; k++) begin
            ctrl_sel_in   = tbl[k].sel;
            ctrl_out_mask = tbl[k].mask;
            do_reset();
            #2;
            chk("tbl_s_tready", 64'(s_tready), 64'(tbl[k].rdy));
            nxt();
            #2;
            chk("tbl_err_sel", 64'(err_sel), 64'(tbl[k].err));
            if (tbl[k].err) begin
                ctrl_sel_in   = 3'd1;
                ctrl_out_mask = 9'h001;
                nxt();
                #2;
                chk("tbl_err_sticky", 64'(err_sel), 64'(1));
            end
        end

        // 4-beat unicast packet on input 1 to output 2
        ctrl_sel_in = 3'd2;
        ctrl_out_mask = 9'h004;
        m_tready = '1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            s_tvalid = '0;
            if (c < 4) put_beat(1, DW'(16'hA0 + c), (c == 3));
            #2;
            if (c < 4) chk("r37_s_tready", 64'(s_tready), 64'(6'b000010));
            chk("r37_pkt_active", 64'(pkt_active), 64'(c >= 1 && c <= 3));
            chk("r37_m_tvalid", 64'(m_tvalid), (c >= 1 && c <= 4) ? 64'h004 : 64'h000);
            if (c >= 1 && c <= 4) chk("r37_m_tdata", 64'(m_tdata), 64'(16'hA0 + c - 1));
            nxt();
        end
        chk("r37_beat_count", 64'(beat_count), 64'(4));

        // multicast to outputs 0 and 6 with output 6 stalled 3 cycles
        mv38 = '{9'h000, 9'h041, 9'h040, 9'h040, 9'h040, 9'h000};
        ctrl_sel_in = 3'd1;
        ctrl_out_mask = 9'h041;
        m_tready = 9'h1bf;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            s_tvalid = '0;
            if (c == 0) put_beat(0, 16'h5a5a, 1'b1);
            if (c == 4) m_tready[6] = 1'b1;
            #2;
            chk("r38_m_tvalid", 64'(m_tvalid), 64'(mv38[c]));
            if (mv38[c] != '0) chk("r38_m_tdata", 64'(m_tdata), 64'(16'h5a5a));
            chk("r38_pkt_active", 64'(pkt_active), 64'(0));
            nxt();
        end
        chk("r38_beat_count", 64'(beat_count), 64'(1));

        // ctrl change mid-packet is ignored
        ctrl_sel_in = 3'd1;
        ctrl_out_mask = 9'h001;
        m_tready = '1;
        do_reset();
        s_tvalid = '0;
        put_beat(0, 16'h1111, 1'b0);
        nxt();
        ctrl_sel_in = 3'd3;
        ctrl_out_mask = 9'h002;
        s_tvalid = '0;
        put_beat(0, 16'h2222, 1'b0);
        put_beat(2, 16'h3333, 1'b1);
        #2;
        chk("r39_s_tready_b1", 64'(s_tready), 64'(6'b000001));
        chk("r39_pkt_active_b1", 64'(pkt_active), 64'(1));
        nxt();
        s_tvalid = '0;
        put_beat(0, 16'h4444, 1'b1);
        put_beat(2, 16'h3333, 1'b1);
        #2;
        chk("r39_s_tready_b2", 64'(s_tready), 64'(6'b000001));
        chk("r39_m_tvalid_b2", 64'(m_tvalid), 64'(9'h001));
        chk("r39_m_tdata_b2", 64'(m_tdata), 64'(16'h2222));
        nxt();
        s_tvalid = '0;
        put_beat(2, 16'h3333, 1'b1);
        #2;
        chk("r39_s_tready_after", 64'(s_tready), 64'(6'b000100));
        chk("r39_pkt_active_after", 64'(pkt_active), 64'(0));
        chk("r39_err_sel", 64'(err_sel), 64'(0));
        nxt();
        drive_idle();
        repeat (3) nxt();

        // randomized stream with mid-packet resets and counter clears
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n         = !(c == 1200 || c == 2100 || c == 2101);
            ctrl_sel_in   = SW'($urandom_range(1, NI));
            ctrl_out_mask = NO'($urandom_range(1, (1 << NO) - 1));
            s_tvalid      = NI'($urandom);
            for (int p = 0; p < NI; p++) begin
                s_tdata[p*DW +: DW] = DW'($urandom);
                s_tlast[p*LW +: LW] = {LW'($urandom) & ~LW'(1), ($urandom_range(0, 3) == 0)};
            end
            m_tready = NO'($urandom | $urandom);
            cnt_clr  = ($urandom_range(0, 63) == 0);
            nxt();
        end

        // drain
        rst_n = 1'b1;
        drive_idle();
        m_tready = '1;
        repeat (6) nxt();
        #2;
        chk("drain_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("drain_model_empty", 64'(q.size()), 64'(0));
        chk("drain_err_sel", 64'(err_sel), 64'(0));

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
